// File: rtl/board_input_scanner.sv
// Board input scanner: synchronises and debounces slide switches and push
// buttons, then presents stable levels, one-cycle press pulses and a
// valid/ready press-event stream with a sticky overflow flag.
module board_input_scanner #(
    parameter int NUM_SW       = 16,
    parameter int NUM_BTN      = 5,
    parameter int CODE_W       = 3,
    parameter int TICK_CYCLES  = 8000,
    parameter int STABLE_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SW-1:0]   sw_in,
    input  logic [NUM_BTN-1:0]  btn_in,
    output logic [NUM_SW-1:0]   sw_state,
    output logic [NUM_BTN-1:0]  btn_state,
    output logic                sw_changed,
    output logic [NUM_BTN-1:0]  btn_pulse,
    output logic                evt_valid,
    output logic [CODE_W-1:0]   evt_code,
    input  logic                evt_ready,
    output logic                evt_overflow,
    input  logic                ovf_clr
);

    // Switches occupy the low bits, buttons the high bits of one input vector.
    localparam int N_IN  = NUM_SW + NUM_BTN;
    localparam int PRE_W = $clog2(TICK_CYCLES);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    logic [N_IN-1:0]    raw;
    logic [N_IN-1:0]    sync_1;
    logic [N_IN-1:0]    sync_2;
    logic [N_IN-1:0]    state;
    logic [N_IN-1:0]    accept;
    logic [CNT_W-1:0]   stab_cnt [N_IN];
    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] pend;
    logic [NUM_BTN-1:0] clr_mask;
    logic               ovf_set;

    assign raw       = {btn_in, sw_in};
    assign sw_state  = state[NUM_SW-1:0];
    assign btn_state = state[N_IN-1:NUM_SW];
    assign tick      = (pre_cnt == PRE_W'(TICK_CYCLES - 1));

    // Two-flop synchroniser on every raw pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Sample-tick prescaler, wraps at TICK_CYCLES-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PRE_W'(1);
    end

    // An input flips when this tick is its STABLE_TICKS-th consecutive differing sample.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_IN; i++) begin
            accept[i] = tick && (sync_2[i] != state[i]) &&
                        (stab_cnt[i] == CNT_W'(STABLE_TICKS - 1));
        end
    end

    // Debounce state and per-input stable counters, advanced on ticks only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
            for (int i = 0; i < N_IN; i++) stab_cnt[i] <= '0;
        end else if (tick) begin
            state <= state ^ accept;
            for (int i = 0; i < N_IN; i++) begin
                if ((sync_2[i] == state[i]) || accept[i]) stab_cnt[i] <= '0;
                else                                       stab_cnt[i] <= stab_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Change pulses, registered so they line up with the state flop update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_changed <= 1'b0;
            btn_pulse  <= '0;
        end else begin
            sw_changed <= |accept[NUM_SW-1:0];
            btn_pulse  <= accept[N_IN-1:NUM_SW] & sync_2[N_IN-1:NUM_SW];
        end
    end

    // Event presentation decoded from the pending flops only (lowest index wins).
    always_comb begin
        evt_code = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend[i]) evt_code = CODE_W'(i);
        end
    end

    assign evt_valid = |pend;

    // One-hot mask of the pending bit retired by this cycle's handshake.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            clr_mask[i] = evt_valid && evt_ready && (evt_code == CODE_W'(i));
        end
    end

    assign ovf_set = |(btn_pulse & pend & ~clr_mask);

    // Pending events (set beats clear) and sticky overflow (set beats clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend         <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pend <= (pend & ~clr_mask) | btn_pulse;
            if (ovf_set)      evt_overflow <= 1'b1;
            else if (ovf_clr) evt_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_board_input_scanner.sv
// Self-checking bench for board_input_scanner: directed scenarios followed by
// random stimulus, compared each cycle against a window-based reference model.
module tb_board_input_scanner;

    localparam int NUM_SW  = 16;
    localparam int NUM_BTN = 5;
    localparam int CODE_W  = 3;
    localparam int TICK    = 4;
    localparam int STABLE  = 4;
    localparam int N_IN    = NUM_SW + NUM_BTN;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_SW-1:0]   sw_in;
    logic [NUM_BTN-1:0]  btn_in;
    logic [NUM_SW-1:0]   sw_state;
    logic [NUM_BTN-1:0]  btn_state;
    logic                sw_changed;
    logic [NUM_BTN-1:0]  btn_pulse;
    logic                evt_valid;
    logic [CODE_W-1:0]   evt_code;
    logic                evt_ready;
    logic                evt_overflow;
    logic                ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    board_input_scanner #(
        .NUM_SW(NUM_SW), .NUM_BTN(NUM_BTN), .CODE_W(CODE_W),
        .TICK_CYCLES(TICK), .STABLE_TICKS(STABLE)
    ) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in), .btn_in(btn_in),
        .sw_state(sw_state), .btn_state(btn_state), .sw_changed(sw_changed),
        .btn_pulse(btn_pulse), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_ready(evt_ready), .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: raw pins reach the debouncer two edges late; a tick
    // flips an input when the last STABLE tick samples all disagree with it.
    logic [N_IN-1:0]    sync_q [$];
    logic [N_IN-1:0]    win_q  [$];
    int                 m_cyc;
    logic [N_IN-1:0]    m_state;
    logic               m_sw_chg;
    logic [NUM_BTN-1:0] m_pulse;
    logic [NUM_BTN-1:0] m_pend;
    logic               m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_code();
        for (int i = 0; i < NUM_BTN; i++) if (m_pend[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        sync_q.delete();
        win_q.delete();
        repeat (2) sync_q.push_back('0);
        repeat (STABLE) win_q.push_back('0);
        m_cyc    = 0;
        m_state  = '0;
        m_sw_chg = 1'b0;
        m_pulse  = '0;
        m_pend   = '0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step();
        logic [N_IN-1:0]    smp;
        logic [N_IN-1:0]    nxt;
        logic [NUM_BTN-1:0] clr;
        logic               ovf_set;
        logic               all_diff;
        smp = sync_q.pop_front();
        sync_q.push_back({btn_in, sw_in});
        clr = '0;
        if (m_pend != 0 && evt_ready) clr[m_code()] = 1'b1;
        ovf_set = |(m_pulse & m_pend & ~clr);
        m_pend  = (m_pend & ~clr) | m_pulse;
        if (ovf_set)      m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_pulse  = '0;
        m_sw_chg = 1'b0;
        if (m_cyc % TICK == TICK - 1) begin
            void'(win_q.pop_front());
            win_q.push_back(smp);
            nxt = m_state;
            for (int i = 0; i < N_IN; i++) begin
                all_diff = 1'b1;
                foreach (win_q[k]) if (win_q[k][i] == m_state[i]) all_diff = 1'b0;
                if (all_diff) begin
                    nxt[i] = ~m_state[i];
                    if (i < NUM_SW)  m_sw_chg = 1'b1;
                    else if (nxt[i]) m_pulse[i-NUM_SW] = 1'b1;
                end
            end
            m_state = nxt;
        end
        m_cyc++;
    endtask

    task automatic check_all();
        chk("sw_state",     32'(sw_state),     32'(m_state[NUM_SW-1:0]));
        chk("btn_state",    32'(btn_state),    32'(m_state[N_IN-1:NUM_SW]));
        chk("sw_changed",   32'(sw_changed),   32'(m_sw_chg));
        chk("btn_pulse",    32'(btn_pulse),    32'(m_pulse));
        chk("evt_valid",    32'(evt_valid),    32'(m_pend != 0));
        chk("evt_code",     32'(evt_code),     32'(m_code()));
        chk("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
    endtask

    // One clock: advance the model with the inputs held across this posedge,
    // then compare on the following negedge.
    task automatic cycle();
        if (!reset) model_reset();
        else        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int pulses;
        reset = 1'b0; sw_in = '0; btn_in = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        @(negedge clk);

        // 1: reset, then idle
        repeat (3) cycle();
        reset = 1'b1;
        repeat (50) cycle();
        chk("idle_valid", 32'(evt_valid), 32'd0);

        // 2: clean press of button 2, no ready
        btn_in[2] = 1'b1;
        pulses = 0;
        repeat (30) begin cycle(); pulses += int'(btn_pulse[2]); end
        chk("b2_pulses", 32'(pulses), 32'd1);
        chk("b2_state",  32'(btn_state[2]), 32'd1);
        chk("b2_code",   32'(evt_code), 32'd2);
        evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
        chk("b2_drained", 32'(evt_valid), 32'd0);

        // 3: button 0 bounces, then settles high
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            btn_in[0] = ((k / 3) % 2) == 0;
            cycle();
            pulses += int'(btn_pulse[0]);
        end
        chk("b0_bounce_pulses", 32'(pulses), 32'd0);
        btn_in[0] = 1'b1;
        pulses = 0;
        repeat (30) begin cycle(); pulses += int'(btn_pulse[0]); end
        chk("b0_settle_pulses", 32'(pulses), 32'd1);
        evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
        btn_in = '0;
        repeat (30) cycle();

        // 4: buttons 1 and 4 together, drained lowest first
        btn_in[1] = 1'b1; btn_in[4] = 1'b1;
        repeat (30) cycle();
        chk("b14_first", 32'(evt_code), 32'd1);
        evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
        chk("b14_second", 32'(evt_code), 32'd4);
        chk("b14_valid",  32'(evt_valid), 32'd1);
        evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
        chk("b14_empty", 32'(evt_valid), 32'd0);
        btn_in = '0;
        repeat (30) cycle();

        // 5: repeat press of button 3 without a handshake -> overflow
        btn_in[3] = 1'b1; repeat (30) cycle();
        btn_in[3] = 1'b0; repeat (30) cycle();
        btn_in[3] = 1'b1; repeat (30) cycle();
        chk("b3_ovf",  32'(evt_overflow), 32'd1);
        chk("b3_code", 32'(evt_code), 32'd3);
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        chk("b3_ovf_clr", 32'(evt_overflow), 32'd0);
        // repeat press landing exactly on the accept edge
        btn_in[3] = 1'b0; repeat (30) cycle();
        btn_in[3] = 1'b1;
        repeat (30) begin evt_ready = m_pulse[3]; cycle(); end
        evt_ready = 1'b0;
        chk("b3_same_valid", 32'(evt_valid), 32'd1);
        chk("b3_same_ovf",   32'(evt_overflow), 32'd0);
        evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
        btn_in = '0;
        repeat (30) cycle();

        // 6: switch pattern with a reset pulse mid-debounce
        sw_in = 16'hA5A5;
        repeat (10) cycle();
        reset = 1'b0;
        #1;
        chk("rst_sw_state", 32'(sw_state), 32'd0);
        chk("rst_valid",    32'(evt_valid), 32'd0);
        @(negedge clk);
        cycle();
        reset = 1'b1;
        pulses = 0;
        repeat (30) begin cycle(); pulses += int'(sw_changed); end
        chk("sw_chg_pulses", 32'(pulses), 32'd1);
        chk("sw_final",      32'(sw_state), 32'hA5A5);

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0)  btn_in ^= NUM_BTN'(1) << $urandom_range(0, NUM_BTN - 1);
            if ($urandom_range(0, 9) == 0)  sw_in  ^= NUM_SW'(1)  << $urandom_range(0, NUM_SW - 1);
            evt_ready = ($urandom_range(0, 3) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 599) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
